wb_intercon_rr: RTL

// - Parametrised N-master / M-slave WISHBONE classic intercon for the SURF register space.
// - Supersedes the fixed 3x6 intercon: round-robin arbitration, registered address decode,
//   ERR on unmapped addresses, optional bus-timeout watchdog.
// - Sits between the bus masters (BM, RACK, SPI) and the register slaves (ID/ctrl, TURFIO, notch, AGC, beam, RFDC).

---
 rtl/wb_intercon_rr.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_intercon_rr.sv
// wb_intercon_rr: N-master / M-slave WISHBONE classic intercon with round-robin arbitration,
// registered address decode and ERR on unmapped addresses. Define WB_INTERCON_TIMEOUT_EN for the bus watchdog.
module wb_intercon_rr #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned NUM_SLAVES     = 6,
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {
    22'h200000, 22'h003000, 22'h002000, 22'h001000, 22'h000800, 22'h000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {
    22'h1FFFFF, 22'h000FFF, 22'h000FFF, 22'h000FFF, 22'h0007FF, 22'h0007FF},
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [NUM_MASTERS-1:0]              m_rty_o,
  output logic [NUM_SLAVES-1:0]               s_cyc_o,
  output logic [NUM_SLAVES-1:0]               s_stb_o,
  output logic                                s_we_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]    s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]    s_dat_i,
  input  logic [NUM_SLAVES-1:0]               s_ack_i,
  input  logic [NUM_SLAVES-1:0]               s_err_i,
  input  logic [NUM_SLAVES-1:0]               s_rty_i,
  output logic [NUM_MASTERS-1:0]              grant_o,
  output logic [NUM_SLAVES-1:0]               ssel_o,
  output logic                                timeout_o
);

  localparam int unsigned NM = NUM_MASTERS;
  localparam int unsigned NS = NUM_SLAVES;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned GW = (NM > 1) ? $clog2(NM) : 1;

  if (NM < 1 || NM > 8) begin : g_bad_nm
    $error("wb_intercon_rr: NUM_MASTERS must be 1..8");
  end
  if (NS < 1 || NS > 16) begin : g_bad_ns
    $error("wb_intercon_rr: NUM_SLAVES must be 1..16");
  end
  if ((DW % 8) != 0 || DW == 0) begin : g_bad_dw
    $error("wb_intercon_rr: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("wb_intercon_rr: TIMEOUT_CYCLES must be >= 2");
  end

  // S_TMO is the single error cycle after a watchdog expiry; unreachable without the watchdog.
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ACTIVE, S_UNMAP, S_TMO} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gidx;
  logic [GW-1:0]   win;
  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat;
  logic [SW-1:0]   g_sel;
  logic [NS-1:0]   hit;
  logic            hit_any;
  logic            sel_ack, sel_err, sel_rty, sel_term;
  logic [DW-1:0]   sel_dat;
  logic            tmo_hit;
  logic            act;
  logic            err_now;

  // gidx doubles as the round-robin pointer: it keeps the last grant after the cycle ends.
  always_comb begin
    g_cyc = m_cyc_i[gidx];
    g_stb = m_stb_i[gidx];
    g_we  = m_we_i[gidx];
    g_adr = m_adr_i[32'(gidx)*AW +: AW];
    g_dat = m_dat_i[32'(gidx)*DW +: DW];
    g_sel = m_sel_i[32'(gidx)*SW +: SW];
  end

  // Later iterations overwrite earlier ones, so offset 1 from the last grant wins.
  always_comb begin
    int unsigned idx;
    win = gidx;
    idx = 0;
    for (int unsigned k = 0; k < NM; k++) begin
      idx = (32'(gidx) + NM - k) % NM;
      if (m_cyc_i[idx]) win = GW'(idx);
    end
  end

  always_comb begin
    int unsigned i;
    hit     = '0;
    hit_any = 1'b0;
    i       = 0;
    for (int unsigned j = 0; j < NS; j++) begin
      i = NS - 1 - j;
      if ((g_adr & ~SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
        hit     = '0;
        hit[i]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ack  = |(ssel_o & s_ack_i);
    sel_err  = |(ssel_o & s_err_i);
    sel_rty  = |(ssel_o & s_rty_i);
    sel_term = sel_ack | sel_err | sel_rty;
    sel_dat  = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (ssel_o[i]) sel_dat = sel_dat | s_dat_i[i*DW +: DW];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (|m_cyc_i) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!g_cyc)       state_nxt = S_IDLE;
        else if (hit_any) state_nxt = S_ACTIVE;
        else              state_nxt = S_UNMAP;
      end
      S_ACTIVE: begin
        if (!g_cyc)        state_nxt = S_IDLE;
        else if (sel_term) state_nxt = S_DECODE;
        else if (tmo_hit)  state_nxt = S_TMO;
      end
      S_UNMAP: begin
        if (!g_cyc)     state_nxt = S_IDLE;
        else if (g_stb) state_nxt = S_DECODE;
      end
      S_TMO:    state_nxt = g_cyc ? S_DECODE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      gidx    <= GW'(NM - 1);
      grant_o <= '0;
      ssel_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (|m_cyc_i) begin
          gidx    <= win;
          grant_o <= NM'(1) << win;
        end
      end else if (state_nxt == S_IDLE) begin
        grant_o <= '0;
      end
      if (state_nxt != S_ACTIVE)  ssel_o <= '0;
      else if (state == S_DECODE) ssel_o <= hit;
    end
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = g_stb && !sel_term && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= (state_nxt == S_TMO);
      if (state != S_ACTIVE || sel_term) tmo_cnt <= '0;
      else if (g_stb)                    tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    act     = (state == S_ACTIVE);
    err_now = (act && sel_err) || (state == S_UNMAP && g_stb) || (state == S_TMO);
    s_cyc_o = act ? (ssel_o & {NS{g_cyc}}) : '0;
    s_stb_o = act ? (ssel_o & {NS{g_stb}}) : '0;
    s_we_o  = g_we;
    s_dat_o = g_dat;
    s_sel_o = g_sel;
    s_adr_o = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      s_adr_o[i*AW +: AW] = g_adr & SLAVE_MASK[i*AW +: AW];
    end
    m_dat_o = act ? sel_dat : '0;
    m_ack_o = grant_o & {NM{act && sel_ack}};
    m_rty_o = grant_o & {NM{act && sel_rty}};
    m_err_o = grant_o & {NM{err_now}};
  end

endmodule
